// File: rtl/pixel_packer_pkg.sv
// Shared widths, beat record and keep-mask helper for the pixel packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pixel_packer_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int PIXEL_W        = 8;
    localparam int WORD_W         = 32;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    // One output beat as presented on the master side.
    typedef struct packed {
        logic [WORD_W-1:0]         data;
        logic [BYTES_PER_WORD-1:0] keep;
        logic                      last;
        logic                      user;
    } beat_t;

    // Lanes 0..lane are enabled; everything above is padding.
    function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [LANE_W-1:0] lane);
        logic [BYTES_PER_WORD-1:0] mask;
        mask = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i <= int'(lane)) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/pixel_packer_out_reg.sv
// Output beat register: loads a finished word, holds it until the master accepts it.
// Latency: 1 cycle from load to valid; frame_done is combinational on the handshake.
// Backpressure: contents frozen while valid && !out_ready; load with retire replaces with no bubble.
module pixel_packer_out_reg
    import pixel_packer_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  beat_t beat_in,
    input  logic  out_ready,
    output logic  out_valid,
    output beat_t beat_out,
    output logic  frame_done
);

    // Load wins over retire so a same-cycle refill keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            beat_out  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            beat_out  <= beat_in;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Frame end is signalled in the cycle the last beat is taken.
    always_comb begin
        frame_done = out_valid && out_ready && beat_out.last;
    end

endmodule

// File: rtl/axis_pixel_packer.sv
// Packs an 8-bit pixel stream into 32-bit beats with frame last/keep (optional SOF user bit: PIXEL_PACKER_SOF_EN).
// Latency: completing pixel accepted at edge N is presented as a valid beat after edge N.
// Backpressure: only the word-completing pixel stalls while an unaccepted beat is held.
module axis_pixel_packer
    import pixel_packer_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                      axi_clk,
    input  logic                      axi_reset_n,
    input  logic                      i_data_valid,
    input  logic [PIXEL_W-1:0]        i_data,
    output logic                      o_data_ready,
    output logic                      o_data_valid,
    output logic [WORD_W-1:0]         o_data,
    output logic [BYTES_PER_WORD-1:0] o_data_keep,
    output logic                      o_data_last,
`ifdef PIXEL_PACKER_SOF_EN
    output logic                      o_data_user,
`endif
    input  logic                      i_data_ready,
    output logic                      o_frame_done
);

    localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    logic [LANE_W-1:0]                      byte_idx;
    logic [CNT_W-1:0]                       pix_cnt;
    logic [BYTES_PER_WORD-1:0][PIXEL_W-1:0] held;
    logic                                   pix_last;
    logic                                   completing;
    logic                                   accept;
    beat_t                                  beat_in;
    beat_t                                  beat_q;

    // Completion and handshake decode from the current accumulator position.
    always_comb begin
        pix_last     = (pix_cnt == CNT_W'(FRAME_PIXELS - 1));
        completing   = (byte_idx == LANE_W'(BYTES_PER_WORD - 1)) || pix_last;
        o_data_ready = axi_reset_n && (!completing || !o_data_valid || i_data_ready);
        accept       = i_data_valid && o_data_ready;
    end

    // Assemble the candidate beat: held lanes below byte_idx, live pixel at byte_idx, zero above.
    always_comb begin
        beat_in = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i == int'(byte_idx)) begin
                beat_in.data[i*PIXEL_W +: PIXEL_W] = i_data;
            end else if (i < int'(byte_idx)) begin
                beat_in.data[i*PIXEL_W +: PIXEL_W] = held[i];
            end
        end
        beat_in.keep = keep_mask(byte_idx);
        beat_in.last = pix_last;
`ifdef PIXEL_PACKER_SOF_EN
        // Words are frame aligned, so the word holds pixel 0 exactly when pix_cnt equals the lane.
        beat_in.user = (pix_cnt == CNT_W'(byte_idx));
`else
        beat_in.user = 1'b0;
`endif
    end

    // Accumulator and frame pixel counter advance on every accepted pixel.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            byte_idx <= '0;
            pix_cnt  <= '0;
            held     <= '0;
        end else if (accept) begin
            held[byte_idx] <= i_data;
            byte_idx       <= completing ? '0 : byte_idx + LANE_W'(1);
            pix_cnt        <= pix_last ? '0 : pix_cnt + CNT_W'(1);
        end
    end

    pixel_packer_out_reg u_out_reg (
        .clk        (axi_clk),
        .rst_n      (axi_reset_n),
        .load       (accept && completing),
        .beat_in    (beat_in),
        .out_ready  (i_data_ready),
        .out_valid  (o_data_valid),
        .beat_out   (beat_q),
        .frame_done (o_frame_done)
    );

    // Unpack the registered beat onto the master ports.
    always_comb begin
        o_data      = beat_q.data;
        o_data_keep = beat_q.keep;
        o_data_last = beat_q.last;
    end

`ifdef PIXEL_PACKER_SOF_EN
    assign o_data_user = beat_q.user;
`else
    logic unused_user;
    assign unused_user = beat_q.user;
`endif

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Directed bench for axis_pixel_packer: an 8x8 instance (a) and a 3x2 instance (b).
// Latency: checks beat appearance the cycle after the completing accept.
// Backpressure: exercises master stalls, reset mid-frame and continuous streaming.
module tb_axis_pixel_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_vld = 1'b0;
    logic [7:0]  a_dat = '0;
    logic        a_rdy, a_ovld, a_last, a_done;
    logic [31:0] a_odat;
    logic [3:0]  a_keep;
    logic        a_ordy = 1'b1;

    logic        b_vld = 1'b0;
    logic [7:0]  b_dat = '0;
    logic        b_rdy, b_ovld, b_last, b_done;
    logic [31:0] b_odat;
    logic [3:0]  b_keep;
    logic        b_ordy = 1'b1;
`ifdef PIXEL_PACKER_SOF_EN
    logic        a_user, b_user;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_pixel_packer #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_a (
        .axi_clk      (clk),
        .axi_reset_n  (rst_n),
        .i_data_valid (a_vld),
        .i_data       (a_dat),
        .o_data_ready (a_rdy),
        .o_data_valid (a_ovld),
        .o_data       (a_odat),
        .o_data_keep  (a_keep),
        .o_data_last  (a_last),
`ifdef PIXEL_PACKER_SOF_EN
        .o_data_user  (a_user),
`endif
        .i_data_ready (a_ordy),
        .o_frame_done (a_done)
    );

    axis_pixel_packer #(.IMG_WIDTH(3), .IMG_HEIGHT(2)) dut_b (
        .axi_clk      (clk),
        .axi_reset_n  (rst_n),
        .i_data_valid (b_vld),
        .i_data       (b_dat),
        .o_data_ready (b_rdy),
        .o_data_valid (b_ovld),
        .o_data       (b_odat),
        .o_data_keep  (b_keep),
        .o_data_last  (b_last),
`ifdef PIXEL_PACKER_SOF_EN
        .o_data_user  (b_user),
`endif
        .i_data_ready (b_ordy),
        .o_frame_done (b_done)
    );

    // Monitor state, sampled mid-cycle on the falling edge.
    logic [31:0] qa_data[$];
    logic [3:0]  qa_keep[$];
    logic        qa_last[$];
    logic [31:0] qb_data[$];
    logic [3:0]  qb_keep[$];
    logic        qb_last[$];
    logic        qb_user[$];
    int          a_bubble = 0;
    int          a_stall_bad = 0;
    int          a_hold_bad = 0;
    int          a_done_cnt = 0;
    int          b_done_cnt = 0;
    int          a_lane = 0;
    logic        a_prev_stall = 1'b0;
    logic [36:0] a_prev_beat = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_lane       <= 0;
            a_prev_stall <= 1'b0;
        end else begin
            if (a_vld && !a_rdy) begin
                a_bubble <= a_bubble + 1;
                if (a_lane != 3) a_stall_bad <= a_stall_bad + 1;
            end
            if (a_vld && a_rdy) a_lane <= (a_lane + 1) % 4;
            if (a_prev_stall && ({a_odat, a_keep, a_last} !== a_prev_beat))
                a_hold_bad <= a_hold_bad + 1;
            a_prev_stall <= a_ovld && !a_ordy;
            a_prev_beat  <= {a_odat, a_keep, a_last};
            if (a_ovld && a_ordy) begin
                qa_data.push_back(a_odat);
                qa_keep.push_back(a_keep);
                qa_last.push_back(a_last);
            end
            if (b_ovld && b_ordy) begin
                qb_data.push_back(b_odat);
                qb_keep.push_back(b_keep);
                qb_last.push_back(b_last);
`ifdef PIXEL_PACKER_SOF_EN
                qb_user.push_back(b_user);
`else
                qb_user.push_back(1'b0);
`endif
            end
            if (a_done) a_done_cnt <= a_done_cnt + 1;
            if (b_done) b_done_cnt <= b_done_cnt + 1;
        end
    end

    task automatic push_a(input logic [7:0] d);
        int   g;
        logic acc;
        g = 0;
        acc = 1'b0;
        a_vld = 1'b1;
        a_dat = d;
        do begin
            @(negedge clk);
            acc = a_rdy;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 200);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_a timeout: ready got 0 required 1 for pixel %h", d);
        end
    endtask

    task automatic push_b(input logic [7:0] d);
        int   g;
        logic acc;
        g = 0;
        acc = 1'b0;
        b_vld = 1'b1;
        b_dat = d;
        do begin
            @(negedge clk);
            acc = b_rdy;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 200);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_b timeout: ready got 0 required 1 for pixel %h", d);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        a_vld = 1'b0;
        b_vld = 1'b0;
        a_ordy = 1'b1;
        b_ordy = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({a_ovld, a_odat, a_keep, a_last, a_done, a_rdy} !== 39'h0) begin
            failures++;
            $display("FAIL reset_a: got v%b d%h k%h l%b fd%b r%b required all 0",
                     a_ovld, a_odat, a_keep, a_last, a_done, a_rdy);
        end
        checks++;
        if ({b_ovld, b_odat, b_keep, b_last, b_done, b_rdy} !== 39'h0) begin
            failures++;
            $display("FAIL reset_b: got v%b d%h k%h l%b fd%b r%b required all 0",
                     b_ovld, b_odat, b_keep, b_last, b_done, b_rdy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got a%b b%b required 1 1", a_rdy, b_rdy);
        end
    endtask

    task automatic test_first_beat();
        push_a(8'h11);
        push_a(8'h22);
        push_a(8'h33);
        checks++;
        if (a_ovld !== 1'b0) begin
            failures++;
            $display("FAIL early_valid: got %b required 0", a_ovld);
        end
        push_a(8'h44);
        a_vld = 1'b0;
        checks++;
        if (a_ovld !== 1'b1) begin
            failures++;
            $display("FAIL first_valid: got %b required 1", a_ovld);
        end
        checks++;
        if (a_odat !== 32'h44332211 || a_keep !== 4'hF || a_last !== 1'b0) begin
            failures++;
            $display("FAIL first_beat: got %h/%h/%b required 44332211/f/0", a_odat, a_keep, a_last);
        end
    endtask

    task automatic test_partial_last();
        int          base;
        int          done0;
        logic [31:0] exp_d[3];
        logic [3:0]  exp_k[3];
        logic        exp_l[3];
        logic        exp_u[3];
        exp_d = '{32'h44332211, 32'h00006655, 32'hA4A3A2A1};
        exp_k = '{4'hF, 4'h3, 4'hF};
        exp_l = '{1'b0, 1'b1, 1'b0};
        exp_u = '{1'b1, 1'b0, 1'b1};
        do_reset();
        base  = qb_data.size();
        done0 = b_done_cnt;
        for (int i = 1; i <= 6; i++) push_b(8'(i * 8'h11));
        for (int i = 1; i <= 4; i++) push_b(8'(8'hA0 + i));
        b_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (qb_data.size() - base !== 3) begin
            failures++;
            $display("FAIL partial_beats: got %0d required 3", qb_data.size() - base);
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (qb_data[base+j] !== exp_d[j] || qb_keep[base+j] !== exp_k[j] || qb_last[base+j] !== exp_l[j]) begin
                    failures++;
                    $display("FAIL partial_beat%0d: got %h/%h/%b required %h/%h/%b", j,
                             qb_data[base+j], qb_keep[base+j], qb_last[base+j], exp_d[j], exp_k[j], exp_l[j]);
                end
`ifdef PIXEL_PACKER_SOF_EN
                checks++;
                if (qb_user[base+j] !== exp_u[j]) begin
                    failures++;
                    $display("FAIL sof_user%0d: got %b required %b", j, qb_user[base+j], exp_u[j]);
                end
`endif
            end
        end
        checks++;
        if (b_done_cnt - done0 !== 1) begin
            failures++;
            $display("FAIL partial_frame_done: got %0d required 1", b_done_cnt - done0);
        end
    endtask

    task automatic test_backpressure();
        int base, bub0, sb0, hb0, bad;
        do_reset();
        base = qa_data.size();
        bub0 = a_bubble;
        sb0  = a_stall_bad;
        hb0  = a_hold_bad;
        fork
            begin
                for (int i = 0; i < 64; i++) push_a(8'(i + 1));
                a_vld = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                a_ordy = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                a_ordy = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (a_bubble - bub0 == 0) begin
            failures++;
            $display("FAIL bp_ready_drop: got 0 stalled cycles required >0");
        end
        checks++;
        if (a_stall_bad - sb0 !== 0) begin
            failures++;
            $display("FAIL bp_stall_lane: got %0d stalls off lane 3 required 0", a_stall_bad - sb0);
        end
        checks++;
        if (a_hold_bad - hb0 !== 0) begin
            failures++;
            $display("FAIL bp_hold: got %0d changes while stalled required 0", a_hold_bad - hb0);
        end
        checks++;
        bad = 0;
        if (qa_data.size() - base !== 16) begin
            bad = 1;
        end else begin
            for (int j = 0; j < 16; j++) begin
                if (qa_data[base+j] !== {8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)} ||
                    qa_keep[base+j] !== 4'hF || qa_last[base+j] !== (j == 15)) bad++;
            end
        end
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_stream: got %0d beats with %0d bad required 16 with 0 bad",
                     qa_data.size() - base, bad);
        end
    endtask

    task automatic test_back_to_back();
        int base, bub0, done0, bad;
        do_reset();
        base  = qa_data.size();
        bub0  = a_bubble;
        done0 = a_done_cnt;
        for (int i = 0; i < 256; i++) push_a(8'(i));
        a_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (a_bubble - bub0 !== 0) begin
            failures++;
            $display("FAIL b2b_bubbles: got %0d required 0", a_bubble - bub0);
        end
        checks++;
        if (a_done_cnt - done0 !== 4) begin
            failures++;
            $display("FAIL b2b_frame_done: got %0d required 4", a_done_cnt - done0);
        end
        checks++;
        bad = 0;
        if (qa_data.size() - base !== 64) begin
            bad = 1;
        end else begin
            for (int j = 0; j < 64; j++) begin
                if (qa_data[base+j] !== {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)} ||
                    qa_keep[base+j] !== 4'hF || qa_last[base+j] !== (j % 16 == 15)) bad++;
            end
        end
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_stream: got %0d beats with %0d bad required 64 with 0 bad",
                     qa_data.size() - base, bad);
        end
    endtask

    task automatic test_reset_mid();
        int base, done0, bad;
        do_reset();
        a_ordy = 1'b0;
        for (int i = 0; i < 6; i++) push_a(8'(8'h50 + i));
        a_vld = 1'b0;
        checks++;
        if (a_ovld !== 1'b1) begin
            failures++;
            $display("FAIL mid_stalled_valid: got %b required 1", a_ovld);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ovld, a_odat, a_keep, a_last, a_done, a_rdy} !== 39'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got v%b d%h k%h l%b fd%b r%b required all 0",
                     a_ovld, a_odat, a_keep, a_last, a_done, a_rdy);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        a_ordy = 1'b1;
        base  = qa_data.size();
        done0 = a_done_cnt;
        for (int i = 1; i <= 4; i++) push_a(8'(8'hC0 + i));
        for (int i = 4; i < 64; i++) push_a(8'(i));
        a_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (qa_data.size() - base < 1 || qa_data[base] !== 32'hC4C3C2C1 || qa_keep[base] !== 4'hF) begin
            failures++;
            $display("FAIL mid_first_beat: got %h/%h required c4c3c2c1/f",
                     (qa_data.size() > base) ? qa_data[base] : 32'h0,
                     (qa_keep.size() > base) ? qa_keep[base] : 4'h0);
        end
        checks++;
        bad = 0;
        if (qa_data.size() - base !== 16) begin
            bad = 1;
        end else begin
            for (int j = 0; j < 16; j++) if (qa_last[base+j] !== (j == 15)) bad++;
        end
        if (bad != 0 || a_done_cnt - done0 !== 1) begin
            failures++;
            $display("FAIL mid_frame_restart: got %0d beats, %0d bad last, %0d done required 16, 0, 1",
                     qa_data.size() - base, bad, a_done_cnt - done0);
        end
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_partial_last();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_pixel_packer.md
# axis_pixel_packer

Downstream neighbour of the convolution top: consumes the 8-bit filtered-pixel AXI-Stream leaving the output buffer and packs four pixels per 32-bit beat for the DMA write channel. It counts pixels per frame, asserts `o_data_last` on the final beat of each frame, and flags partial last words with `o_data_keep`. It has full-throughput valid/ready handshakes on both sides.

## Interface
- `IMG_WIDTH`, 512, output pixels per line.
- `IMG_HEIGHT`, 512, output lines per frame; `FRAME_PIXELS = IMG_WIDTH*IMG_HEIGHT`, must be ≥ 1.
- `axi_clk`  in  1  single clock; all logic rising-edge.
- `axi_reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_data_valid`  in  1  slave pixel valid.
- `i_data`  in  8  slave pixel.
- `o_data_ready`  out  1  slave ready.
- `o_data_valid`  out  1  master beat valid.
- `o_data`  out  32  packed pixels; the first pixel of the word is in `[7:0]`.
- `o_data_keep`  out  4  byte enables of the beat.
- `o_data_last`  out  1  final beat of the frame.
- `i_data_ready`  in  1  master ready.
- `o_frame_done`  out  1  one-cycle pulse when the last beat is accepted.

## Operation
- Accumulator: byte index `byte_idx` (0..3) and up to 3 held bytes; frame pixel counter `pix_cnt` (0..FRAME_PIXELS-1).
- Slave accept = `i_data_valid && o_data_ready`.
  - Each accept stores `i_data` into byte lane `byte_idx` and increments `byte_idx` and `pix_cnt`.
- Word completion on accept when `byte_idx==3` or `pix_cnt==FRAME_PIXELS-1`.
  - Loads the output register: data = held bytes plus the current byte; unused lanes are 0.
  - `keep` = lanes 0..byte_idx set; `last` = (`pix_cnt==FRAME_PIXELS-1`).
  - Clears `byte_idx`.
  - Wraps `pix_cnt` to 0 when `last`.
- `o_data_ready = axi_reset_n && (!completing || !o_data_valid || i_data_ready)`.
  - `completing` is the completion condition evaluated on the current `byte_idx`/`pix_cnt`.
  - Bytes 0–2 are always accepted while a beat is stalled; only the completing byte stalls.
- Master handshake: `o_data_valid && i_data_ready` retires the beat.
  - `o_data_valid` stays set if a new word loads in the same cycle, otherwise it clears.
- `o_data`, `o_data_keep` and `o_data_last` are stable while `o_data_valid && !i_data_ready`.
- `o_frame_done` pulses for 1 cycle on the handshake of a beat with `last`=1.
- Reset (any time, including mid-frame or mid-word):
  - Asynchronously clears `byte_idx`, `pix_cnt`, held bytes and the output register.
  - Partial data is discarded; the next accepted pixel is pixel 0 of a new frame.
- Reset values: `o_data_valid`=0, `o_data`=0, `o_data_keep`=0, `o_data_last`=0, `o_frame_done`=0, `o_data_ready`=0.
  - `o_data_ready` goes to 1 combinationally after reset deasserts.

## Timing
- Latency: the completing pixel accepted at edge N gives `o_data_valid`=1 after edge N (visible in cycle N+1).
- Sustained throughput: 1 pixel/cycle in, 1 beat per 4 cycles out, with `i_data_ready` tied high.
- `o_data_ready` depends combinationally on `i_data_ready`. There is no combinational path from `i_data_valid` to `o_data_valid`.
- Simultaneous retire and load in one cycle: the new beat replaces the old with no bubble.

## Configuration
- `PIXEL_PACKER_SOF_EN` defined: adds port `o_data_user` (out, 1). It equals 1 on the first beat of each frame (the beat containing pixel 0), has the same hold rules as `o_data`, and resets to 0.
- `PIXEL_PACKER_SOF_EN` undefined: the port and its register are absent; behaviour is otherwise identical.

## Structure
- `pixel_packer_pkg`:
  - `BYTES_PER_WORD`=4, `PIXEL_W`=8, `WORD_W`=32.
  - A typedef for the beat struct (data, keep, last, user).
  - A function computing the keep mask from the lane index.
- One sub-module, `pixel_packer_out_reg`: the output beat register with load/retire/hold logic. The top holds the accumulator and counters.

## Test plan
- Pixels 0x11,0x22,0x33,0x44 with ready high, W=4,H=2 -> beat 0x44332211, keep 0xF, last 0; appears the cycle after the 4th accept.
- W=3,H=2, pixels 0x11..0x66 -> beats 0x44332211/keep 0xF/last 0, then 0x00006655/keep 0x3/last 1. `o_frame_done` pulses once; the next frame restarts at lane 0.
- Continuous input, `i_data_ready` low for 10 cycles during a beat:
  - `o_data_ready` drops only on the 4th byte of the next word.
  - The held beat stays unchanged.
  - No pixels are lost or duplicated across 64 pixels.
- `i_data_ready` high and `i_data_valid` high continuously for 4 frames of 8×8 -> 16 beats per frame, zero bubbles in `o_data_ready`, last on every 16th beat.
- `axi_reset_n` pulsed low after pixel 6 of a frame:
  - All outputs are 0 during reset.
  - The following 4 pixels form beat lane 0..3 with keep 0xF.
  - The frame count restarts.
- With `PIXEL_PACKER_SOF_EN`: over 3 frames of W=4,H=1, `o_data_user`=1 exactly on beats 1, 2 and 3 (each frame's first and only beat); without the macro, the build has no `o_data_user` port.
